// File: rtl/tfm_pkg.sv
// Shared encodings and helpers for the ternary vector unit: trit codes, op codes,
// FSM states and the trit multiply used by every lane.
package tfm_pkg;

    localparam logic [1:0] TRIT_ZERO = 2'b00;
    localparam logic [1:0] TRIT_POS  = 2'b01;
    localparam logic [1:0] TRIT_NEG  = 2'b10;
    localparam logic [1:0] TRIT_INV  = 2'b11;

    typedef enum logic [1:0] {
        OP_ACC      = 2'b00,
        OP_ACC_KEEP = 2'b01,
        OP_DOT      = 2'b10,
        OP_EWISE    = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_REDUCE = 2'b10,
        ST_HOLD   = 2'b11
    } state_e;

    function automatic logic trit_bad(input logic [1:0] t);
        return (t == TRIT_INV);
    endfunction

    // Zero and invalid codes both multiply as zero.
    function automatic logic signed [1:0] trit_mul(input logic [1:0] w, input logic [1:0] x);
        logic signed [1:0] p;
        if ((w != TRIT_POS && w != TRIT_NEG) || (x != TRIT_POS && x != TRIT_NEG)) begin
            p = 2'sb00;
        end else if (w == x) begin
            p = 2'sb01;
        end else begin
            p = 2'sb11;
        end
        return p;
    endfunction

endpackage

// File: rtl/tvu_lane.sv
// One saturating ternary MAC lane: load overwrites with the product, add accumulates
// with clamping, clear zeroes the accumulator.
module tvu_lane
    import tfm_pkg::*;
#(
    parameter int ACCUM_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          clear_i,
    input  logic                          load_i,
    input  logic                          add_i,
    input  logic [1:0]                    w_i,
    input  logic [1:0]                    x_i,
    output logic signed [ACCUM_WIDTH-1:0] acc_o,
    output logic                          sat_o
);
    localparam logic signed [ACCUM_WIDTH:0] MAX_V = {2'b00, {(ACCUM_WIDTH-1){1'b1}}};
    localparam logic signed [ACCUM_WIDTH:0] MIN_V = {2'b11, {(ACCUM_WIDTH-1){1'b0}}};

    logic signed [ACCUM_WIDTH-1:0] acc_q;
    logic signed [ACCUM_WIDTH-1:0] acc_d;
    logic signed [1:0]             prod_s;
    logic signed [ACCUM_WIDTH:0]   sum_s;

    // Next accumulator value; the sum carries one guard bit so clamping is exact.
    always_comb begin
        prod_s = trit_mul(w_i, x_i);
        sum_s  = {acc_q[ACCUM_WIDTH-1], acc_q} + {{(ACCUM_WIDTH-1){prod_s[1]}}, prod_s};
        sat_o  = 1'b0;
        acc_d  = acc_q;
        if (load_i) begin
            acc_d = {{(ACCUM_WIDTH-2){prod_s[1]}}, prod_s};
        end else if (add_i) begin
            if (sum_s > MAX_V) begin
                acc_d = MAX_V[ACCUM_WIDTH-1:0];
                sat_o = 1'b1;
            end else if (sum_s < MIN_V) begin
                acc_d = MIN_V[ACCUM_WIDTH-1:0];
                sat_o = 1'b1;
            end else begin
                acc_d = sum_s[ACCUM_WIDTH-1:0];
            end
        end else begin
            acc_d = acc_q;
        end
    end

    // Accumulator register
    always_ff @(posedge clk) begin
        if (clear_i) begin
            acc_q <= {ACCUM_WIDTH{1'b0}};
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/ternary_vector_unit.sv
// SIMD ternary MAC engine: LANES saturating lanes behind a valid/ready beat stream,
// with beat counting, sticky flags, a registered dot-product adder tree and a held result.
module ternary_vector_unit
    import tfm_pkg::*;
#(
    parameter int LANES       = 16,
    parameter int ACCUM_WIDTH = 32,
    parameter int MAX_DEPTH   = 256,
    parameter int DEPTH_W     = 9
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [1:0]                            op_mode,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic                                  in_last,
    input  logic [LANES*2-1:0]                    bus_weights,
    input  logic [LANES*2-1:0]                    bus_inputs,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [LANES*ACCUM_WIDTH-1:0]          vector_out,
    output logic [ACCUM_WIDTH+$clog2(LANES)-1:0]  dot_out,
    output logic [DEPTH_W-1:0]                    beat_count,
    output logic                                  sat_flag,
    output logic                                  err_flag
);
    localparam int LVLS = $clog2(LANES);
    localparam int DW   = ACCUM_WIDTH + LVLS;
    localparam logic [DEPTH_W-1:0] DEPTH_LIM = DEPTH_W'(MAX_DEPTH);
    localparam logic [LVLS:0]      RED_DOT   = (LVLS+1)'(LVLS);

    state_e                        state_q;
    op_e                           mode_q;
    logic [DEPTH_W-1:0]            cnt_q;
    logic [LVLS:0]                 red_cnt_q;
    logic                          sat_q, err_q, out_valid_q;
    logic signed [DW-1:0]          dot_q;
    logic signed [DW-1:0]          tree_q [LANES-1];
    logic signed [DW-1:0]          tree_s [2*LANES-1];
    logic signed [ACCUM_WIDTH-1:0] acc_s [LANES];
    logic [LANES-1:0]              lane_sat_s;
    logic accept_s, first_s, load_s, add_s, bad_s, depth_hit_s, ewise_s, end_s, forced_s;
    logic [DEPTH_W-1:0]            cnt_next_s;
    logic [LVLS:0]                 red_tgt_s;

    assign in_ready = !reset && (state_q == ST_IDLE || state_q == ST_RUN);

    // Beat decode: lane controls, depth tracking and end-of-vector detection
    always_comb begin
        accept_s    = in_valid && in_ready;
        first_s     = accept_s && (state_q == ST_IDLE);
        load_s      = first_s && (op_e'(op_mode) != OP_ACC_KEEP);
        add_s       = accept_s && !load_s;
        cnt_next_s  = first_s ? DEPTH_W'(1) : (cnt_q + DEPTH_W'(1));
        depth_hit_s = (cnt_next_s == DEPTH_LIM);
        ewise_s     = first_s && (op_e'(op_mode) == OP_EWISE);
        end_s       = in_last || depth_hit_s || ewise_s;
        forced_s    = depth_hit_s && !in_last && !ewise_s;
        red_tgt_s   = (mode_q == OP_DOT) ? RED_DOT : {(LVLS+1){1'b0}};
        bad_s       = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            bad_s = bad_s | trit_bad(bus_weights[2*i +: 2]) | trit_bad(bus_inputs[2*i +: 2]);
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        tvu_lane #(.ACCUM_WIDTH(ACCUM_WIDTH)) u_lane (
            .clk     (clk),
            .clear_i (reset),
            .load_i  (load_s),
            .add_i   (add_s),
            .w_i     (bus_weights[2*g +: 2]),
            .x_i     (bus_inputs[2*g +: 2]),
            .acc_o   (acc_s[g]),
            .sat_o   (lane_sat_s[g])
        );
        assign vector_out[g*ACCUM_WIDTH +: ACCUM_WIDTH] = acc_s[g];
    end

    // Heap-ordered tree view: internal nodes are registers, leaves are the sign-extended lanes
    always_comb begin
        for (int i = 0; i < LANES-1; i++) begin
            tree_s[i] = tree_q[i];
        end
        for (int i = 0; i < LANES; i++) begin
            tree_s[LANES-1+i] = DW'(acc_s[i]);
        end
    end

    // Free-running pipelined adder tree; the root settles LVLS cycles after the lanes stop
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LANES-1; i++) begin
                tree_q[i] <= {DW{1'b0}};
            end
        end else begin
            for (int i = 0; i < LANES-1; i++) begin
                tree_q[i] <= tree_s[2*i+1] + tree_s[2*i+2];
            end
        end
    end

    // Control FSM with registered result handshake, counters and sticky flags.
    // REDUCE also provides the one-cycle result stage for the non-DOT modes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            mode_q      <= OP_ACC;
            cnt_q       <= {DEPTH_W{1'b0}};
            red_cnt_q   <= {(LVLS+1){1'b0}};
            sat_q       <= 1'b0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            dot_q       <= {DW{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (first_s) begin
                        mode_q    <= op_e'(op_mode);
                        cnt_q     <= cnt_next_s;
                        sat_q     <= |lane_sat_s;
                        err_q     <= bad_s || forced_s;
                        dot_q     <= {DW{1'b0}};
                        red_cnt_q <= {(LVLS+1){1'b0}};
                        state_q   <= end_s ? ST_REDUCE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (accept_s) begin
                        cnt_q     <= cnt_next_s;
                        sat_q     <= sat_q || (|lane_sat_s);
                        err_q     <= err_q || bad_s || forced_s;
                        red_cnt_q <= {(LVLS+1){1'b0}};
                        if (end_s) begin
                            state_q <= ST_REDUCE;
                        end
                    end
                end
                ST_REDUCE: begin
                    red_cnt_q <= red_cnt_q + (LVLS+1)'(1);
                    if (red_cnt_q == red_tgt_s) begin
                        state_q     <= ST_HOLD;
                        out_valid_q <= 1'b1;
                        if (mode_q == OP_DOT) begin
                            dot_q <= tree_s[0];
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid  = out_valid_q;
    assign dot_out    = dot_q;
    assign beat_count = cnt_q;
    assign sat_flag   = sat_q;
    assign err_flag   = err_q;

endmodule

// File: tb/tb_ternary_vector_unit.sv
// Scoreboard bench: three unit instances (default, 4-bit accumulators, depth limit 8)
// share stimulus; a behavioural model predicts each result when its last beat is driven.
module tb_ternary_vector_unit;

    localparam logic [31:0] T_POS = 32'h5555_5555;
    localparam logic [31:0] T_NEG = 32'hAAAA_AAAA;
    localparam logic [31:0] T_ALT = 32'h9999_9999;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, in_valid, in_last, out_ready;
    logic [1:0] op_mode, sel;
    logic [31:0] bus_w, bus_x;
    logic iv_a, iv_b, iv_c, rdy_a, rdy_b, rdy_c, ov_a, ov_b, ov_c;
    logic sat_a, sat_b, sat_c, err_a, err_b, err_c;
    logic [16*32-1:0] vo_a, vo_c;
    logic [16*4-1:0]  vo_b;
    logic [35:0] dot_a, dot_c;
    logic [7:0]  dot_b;
    logic [8:0]  cnt_a, cnt_b;
    logic [3:0]  cnt_c;
    logic rdy_s, ov_s, sat_s, err_s;

    assign iv_a  = in_valid && (sel == 2'd0);
    assign iv_b  = in_valid && (sel == 2'd1);
    assign iv_c  = in_valid && (sel == 2'd2);
    assign rdy_s = (sel == 2'd0) ? rdy_a : (sel == 2'd1) ? rdy_b : rdy_c;
    assign ov_s  = (sel == 2'd0) ? ov_a  : (sel == 2'd1) ? ov_b  : ov_c;
    assign sat_s = (sel == 2'd0) ? sat_a : (sel == 2'd1) ? sat_b : sat_c;
    assign err_s = (sel == 2'd0) ? err_a : (sel == 2'd1) ? err_b : err_c;

    ternary_vector_unit dut_a (
        .clk(clk), .reset(reset), .op_mode(op_mode), .in_valid(iv_a), .in_ready(rdy_a),
        .in_last(in_last), .bus_weights(bus_w), .bus_inputs(bus_x), .out_valid(ov_a),
        .out_ready(out_ready), .vector_out(vo_a), .dot_out(dot_a), .beat_count(cnt_a),
        .sat_flag(sat_a), .err_flag(err_a));

    ternary_vector_unit #(.ACCUM_WIDTH(4)) dut_b (
        .clk(clk), .reset(reset), .op_mode(op_mode), .in_valid(iv_b), .in_ready(rdy_b),
        .in_last(in_last), .bus_weights(bus_w), .bus_inputs(bus_x), .out_valid(ov_b),
        .out_ready(out_ready), .vector_out(vo_b), .dot_out(dot_b), .beat_count(cnt_b),
        .sat_flag(sat_b), .err_flag(err_b));

    ternary_vector_unit #(.MAX_DEPTH(8), .DEPTH_W(4)) dut_c (
        .clk(clk), .reset(reset), .op_mode(op_mode), .in_valid(iv_c), .in_ready(rdy_c),
        .in_last(in_last), .bus_weights(bus_w), .bus_inputs(bus_x), .out_valid(ov_c),
        .out_ready(out_ready), .vector_out(vo_c), .dot_out(dot_c), .beat_count(cnt_c),
        .sat_flag(sat_c), .err_flag(err_c));

    typedef struct {
        longint lane[16];
        longint dot;
        int     cnt;
        bit     sat;
        bit     err;
        int     lat;
    } exp_t;

    exp_t   sb_q[$];
    longint m_acc[3][16];
    int     m_cnt;
    bit     m_sat, m_err, m_active;
    logic [1:0] m_mode;
    int     n_checks = 0;
    int     n_fail   = 0;

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint lane_of(input int i);
        case (sel)
            2'd0:    return longint'($signed(vo_a[i*32 +: 32]));
            2'd1:    return longint'($signed(vo_b[i*4 +: 4]));
            default: return longint'($signed(vo_c[i*32 +: 32]));
        endcase
    endfunction

    function automatic longint dot_of();
        case (sel)
            2'd0:    return longint'($signed(dot_a));
            2'd1:    return longint'($signed(dot_b));
            default: return longint'($signed(dot_c));
        endcase
    endfunction

    function automatic int cnt_of();
        case (sel)
            2'd0:    return int'(cnt_a);
            2'd1:    return int'(cnt_b);
            default: return int'(cnt_c);
        endcase
    endfunction

    function automatic int tval(input logic [1:0] t);
        if (t == 2'b01) return 1;
        else if (t == 2'b10) return -1;
        else return 0;
    endfunction

    task automatic model_clear();
        for (int d = 0; d < 3; d++)
            for (int i = 0; i < 16; i++) m_acc[d][i] = 0;
        m_active = 1'b0;
        sb_q.delete();
    endtask

    task automatic model_beat(input logic [1:0] mode, input logic [31:0] w,
                              input logic [31:0] x, input bit last);
        bit first, ew;
        int aw, maxd;
        longint hi, lo, sum, p;
        exp_t e;
        aw   = (sel == 2'd1) ? 4 : 32;
        maxd = (sel == 2'd2) ? 8 : 256;
        hi   = (longint'(1) <<< (aw - 1)) - 1;
        lo   = -(longint'(1) <<< (aw - 1));
        first = !m_active;
        if (first) begin
            m_mode = mode; m_cnt = 0; m_sat = 1'b0; m_err = 1'b0; m_active = 1'b1;
        end
        ew = first && (mode == 2'b11);
        m_cnt++;
        for (int i = 0; i < 16; i++) begin
            if (w[2*i +: 2] == 2'b11 || x[2*i +: 2] == 2'b11) m_err = 1'b1;
            p = tval(w[2*i +: 2]) * tval(x[2*i +: 2]);
            if (first && mode != 2'b01) m_acc[sel][i] = p;
            else m_acc[sel][i] = m_acc[sel][i] + p;
            if (m_acc[sel][i] > hi) begin m_acc[sel][i] = hi; m_sat = 1'b1; end
            if (m_acc[sel][i] < lo) begin m_acc[sel][i] = lo; m_sat = 1'b1; end
        end
        if (m_cnt == maxd && !last && !ew) m_err = 1'b1;
        if (last || m_cnt == maxd || ew) begin
            sum = 0;
            for (int i = 0; i < 16; i++) begin
                e.lane[i] = m_acc[sel][i];
                sum += m_acc[sel][i];
            end
            e.dot = (m_mode == 2'b10) ? sum : 0;
            e.cnt = m_cnt; e.sat = m_sat; e.err = m_err;
            e.lat = (m_mode == 2'b10) ? 5 : 1;
            sb_q.push_back(e);
            m_active = 1'b0;
        end
    endtask

    task automatic drive_beat(input logic [1:0] mode, input logic [31:0] w,
                              input logic [31:0] x, input bit last);
        int waited = 0;
        op_mode = mode; bus_w = w; bus_x = x; in_last = last; in_valid = 1'b1;
        while (!rdy_s && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!rdy_s) begin
            check_eq("accept_timeout", 0, 1);
        end else begin
            model_beat(mode, w, x, last);
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_result(input string tag, input int hold);
        exp_t e;
        int n = 0;
        if (sb_q.size() == 0) begin
            check_eq({tag, "_sb_empty"}, 0, 1);
            return;
        end
        e = sb_q.pop_front();
        while (!ov_s && n < 300) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_latency"}, n, e.lat);
        if (ov_s) begin
            for (int i = 0; i < 16; i++)
                check_eq($sformatf("%s_lane%0d", tag, i), lane_of(i), e.lane[i]);
            check_eq({tag, "_dot"}, dot_of(), e.dot);
            check_eq({tag, "_cnt"}, cnt_of(), e.cnt);
            check_eq({tag, "_sat"}, sat_s, e.sat);
            check_eq({tag, "_err"}, err_s, e.err);
            check_eq({tag, "_rdy_hold"}, rdy_s, 0);
            for (int c = 0; c < hold; c++) begin
                @(negedge clk);
                check_eq({tag, "_hold_ov"}, ov_s, 1);
                check_eq({tag, "_hold_rdy"}, rdy_s, 0);
                check_eq({tag, "_hold_lane0"}, lane_of(0), e.lane[0]);
                check_eq({tag, "_hold_cnt"}, cnt_of(), e.cnt);
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            check_eq({tag, "_ov_drop"}, ov_s, 0);
            check_eq({tag, "_rdy_back"}, rdy_s, 1);
        end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        op_mode = 2'b00; sel = 2'd0; bus_w = 32'h0; bus_x = 32'h0;
        repeat (3) @(negedge clk);
        check_eq("rst_rdy", rdy_a, 0);
        check_eq("rst_ov", ov_a, 0);
        check_eq("rst_lane0", lane_of(0), 0);
        check_eq("rst_dot", dot_of(), 0);
        check_eq("rst_cnt", cnt_of(), 0);
        check_eq("rst_flags", {sat_a, err_a}, 0);
        reset = 1'b0;
        model_clear();
        @(negedge clk);
        check_eq("idle_rdy", rdy_a, 1);

        for (int b = 0; b < 4; b++) drive_beat(2'b00, T_POS, T_POS, b == 3);
        wait_result("acc4", 0);
        for (int b = 0; b < 2; b++) drive_beat(2'b01, T_NEG, T_POS, b == 1);
        wait_result("keep2", 0);
        drive_beat(2'b00, T_NEG, T_POS, 1'b1);
        wait_result("acc1", 0);
        for (int b = 0; b < 3; b++) drive_beat(2'b10, T_POS, T_ALT, b == 2);
        wait_result("dot_alt", 0);
        drive_beat(2'b10, T_POS, T_POS, 1'b0);
        drive_beat(2'b10, 32'h5555_5557, T_POS, 1'b1);
        wait_result("dot_inv", 0);
        drive_beat(2'b11, T_NEG, T_ALT, 1'b0);
        wait_result("ewise", 0);

        sel = 2'd1;
        for (int b = 0; b < 9; b++) drive_beat(2'b00, T_POS, T_POS, b == 8);
        wait_result("sat4", 0);

        sel = 2'd2;
        for (int b = 0; b < 8; b++) drive_beat(2'b00, T_POS, T_NEG, 1'b0);
        op_mode = 2'b00; bus_w = T_POS; bus_x = T_POS; in_valid = 1'b1;
        check_eq("depth_stall", rdy_s, 0);
        wait_result("depth8", 3);
        in_valid = 1'b0;

        sel = 2'd0;
        for (int b = 0; b < 3; b++) drive_beat(2'b00, T_POS, T_NEG, b == 2);
        wait_result("hold5", 5);
        drive_beat(2'b00, T_POS, T_POS, 1'b0);
        drive_beat(2'b00, T_POS, T_POS, 1'b0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("mid_rst_rdy", rdy_a, 0);
        check_eq("mid_rst_ov", ov_a, 0);
        check_eq("mid_rst_lane0", lane_of(0), 0);
        check_eq("mid_rst_cnt", cnt_of(), 0);
        check_eq("mid_rst_dot", dot_of(), 0);
        reset = 1'b0;
        model_clear();
        repeat (4) @(negedge clk);
        check_eq("post_rst_ov", ov_a, 0);
        check_eq("post_rst_rdy", rdy_a, 1);
        check_eq("post_rst_flags", {sat_a, err_a}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
